midi_uart_rx: RTL and testbench
===============================

# midi_uart_rx

Serial MIDI receiver sitting directly upstream of the MIDI audio unit. It samples the opto-isolated MIDI input line (31 250 baud, 8N1) and recovers each byte. It drives the byte/strobe pair consumed as `iMidiRd`/`iMidiRe` by the MIDI decoder. Real-time bytes can be filtered out so they never disturb running-status parsing downstream.

## Interface
Parameters:
- `pClkFreq`, default 48_000_000: system clock frequency in Hz.
- `pBaud`, default 31_250: MIDI bit rate.
- `pFilterRealTime`, default "yes": "yes" drops bytes 0xF8–0xFF; "no" passes them through.
- `pSim`, default "no": "yes" forces the bit divider D to 16 for fast simulation.

Ports:
- `iCLK`, in, 1: system clock; the block's only clock.
- `iRST`, in, 1: reset, synchronous, active-high.
- `iMidiRx`, in, 1: asynchronous MIDI serial line; idles high.
- `oMidiRd`, out, 8: last accepted byte; held until the next accepted byte.
- `oMidiRe`, out, 1: one-cycle strobe; `oMidiRd` is valid in the same cycle.
- `oFrameErr`, out, 1: one-cycle pulse on a stop-bit error.
- `oBusy`, out, 1: high whenever the FSM is not in IDLE.

## Operation
- Divider D = pClkFreq/pBaud (1536 at the defaults), or 16 when pSim="yes". The bit counter is 16 bits wide; D must satisfy 16 ≤ D ≤ 65535. Half-bit H = D/2, truncated.
- Input synchronizer: two flip-flops, both reset to 1. All decisions use the second flop, called `rx_s`.
- FSM states:
  - IDLE: when `rx_s`=0, load counter = H-1 and go to START.
  - START: at counter expiry, sample `rx_s`.
    - If 0: load D-1, clear bit index, go to DATA.
    - If 1 (glitch): return to IDLE with no output.
  - DATA: at each expiry, shift `rx_s` into the shift register LSB-first and reload D-1. After bit 7, go to STOP.
  - STOP: at expiry, sample `rx_s`.
    - If 1: byte is complete; go to IDLE.
    - If 0: pulse `oFrameErr`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from re-triggering reception.
- Accept rule for a complete byte:
  - If pFilterRealTime="yes" and byte ≥ 0xF8: no strobe, and `oMidiRd` is not updated.
  - Otherwise: register the byte into `oMidiRd` and pulse `oMidiRe`.
- No buffering. A byte is delivered at most once every 10·D cycles, so the downstream block must accept `oMidiRe` in every cycle it occurs (no back-pressure).
- Reset mid-frame: the partial byte is discarded with no strobe. The FSM returns to IDLE and the synchronizer reads idle-high.

## Timing
- Reset values: `oMidiRd`=0x00, `oMidiRe`=0, `oFrameErr`=0, `oBusy`=0, FSM in IDLE, both synchronizer flops at 1.
- Let t0 be the first cycle `rx_s`=0 while in IDLE. The pin falls 2 cycles before t0.
- Sample times:
  - Start-bit sample at t0+H.
  - Data bit i (i = 0..7) sampled at t0+H+(i+1)·D.
  - Stop-bit sample at ts = t0+H+9·D.
- `oMidiRe` or `oFrameErr` is high in cycle ts+1 only.
- The FSM is in IDLE at ts+1 after a good stop bit, so the next start edge is detectable from ts+1 onward.
- `oBusy` rises at t0+1. It falls at ts+1 on a good stop bit, or when BREAK exits.
- `oMidiRe` and `oFrameErr` are never high in the same cycle.

## Test plan
All scenarios use pSim="yes", so D=16 and H=8.
- Reset check: hold `iRST` 3 cycles while driving `iMidiRx`=0 → all outputs at reset values; no `oMidiRe` after release until a full frame is received.
- Note On stream: send 0x90, 0x3C, 0x64 back-to-back, with the stop bit immediately followed by the next start bit.
  - Required: exactly three `oMidiRe` pulses carrying 0x90, 0x3C, 0x64.
  - Each pulse falls at t0+H+9·D+1 relative to its own t0.
- Real-time filter: send 0x90, 0xF8, 0x3C with pFilterRealTime="yes" → strobes for 0x90 and 0x3C only, and `oMidiRd` stays 0x90 through the 0xF8 frame. Repeat with "no" → three strobes.
- Framing error: send 0x55 with the stop bit low, hold the line low 40 cycles, then send 0xA5.
  - Required: one `oFrameErr` pulse, no strobe for 0x55, `oBusy` high during the low hold.
  - 0xA5 is then received correctly.
- Start glitch: drive `iMidiRx` low for 3 cycles, then high → no output, and `oBusy` back at 0 by t0+H+1.
- Mid-frame reset: assert `iRST` during data bit 4 of 0x3C, then send 0x7F → no strobe for the partial byte; 0x7F is received correctly.

Source files
------------

// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 8N1 at pBaud, mid-bit sampling from a two-flop synchronizer,
// optional suppression of real-time bytes (0xF8-0xFF) before they reach the decoder.
module midi_uart_rx #(
  parameter int    pClkFreq        = 48_000_000,
  parameter int    pBaud           = 31_250,
  parameter string pFilterRealTime = "yes",
  parameter string pSim            = "no"
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iMidiRx,
  output logic [7:0] oMidiRd,
  output logic       oMidiRe,
  output logic       oFrameErr,
  output logic       oBusy
);

  localparam int          D         = (pSim == "yes") ? 16 : pClkFreq / pBaud;
  localparam logic [15:0] D_M1      = 16'(D - 1);
  localparam logic [15:0] H_M1      = 16'(D / 2 - 1);
  localparam bit          FILTER_RT = (pFilterRealTime == "yes");

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rd_q, rd_d;
  logic        re_q, re_d;
  logic        ferr_q, ferr_d;
  logic        expire;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rd_q    <= '0;
      re_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= iMidiRx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rd_q    <= rd_d;
      re_q    <= re_d;
      ferr_q  <= ferr_d;
    end
  end

  assign expire = (cnt_q == 16'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rd_d    = rd_q;
    re_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          cnt_d   = H_M1;
          state_d = START;
        end
      end
      START: begin
        if (!expire) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rx_s_q) begin
          cnt_d   = D_M1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = D_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s_q) begin
          state_d = IDLE;
          // Real-time bytes are dropped entirely so running status downstream is untouched.
          if (!(FILTER_RT && shift_q >= 8'hF8)) begin
            rd_d = shift_q;
            re_d = 1'b1;
          end
        end else begin
          ferr_d  = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign oMidiRd   = rd_q;
  assign oMidiRe   = re_q;
  assign oFrameErr = ferr_q;
  assign oBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx with D=16: one filtering and one pass-through instance
// share the serial line; each scenario task checks its own results.
module tb_midi_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rd, rd_nf;
  logic       re, re_nf, ferr, ferr_nf, busy, busy_nf;
  int         cyc = 0;

  int tests  = 0;
  int errors = 0;

  logic [7:0] got_bytes[$];
  int         got_cyc[$];
  logic [7:0] nf_bytes[$];
  int         ferr_cnt = 0;
  int         overlap  = 0;

  midi_uart_rx #(.pSim("yes"), .pFilterRealTime("yes")) dut (
    .iCLK(clk), .iRST(rst), .iMidiRx(rx),
    .oMidiRd(rd), .oMidiRe(re), .oFrameErr(ferr), .oBusy(busy)
  );

  midi_uart_rx #(.pSim("yes"), .pFilterRealTime("no")) dut_nf (
    .iCLK(clk), .iRST(rst), .iMidiRx(rx),
    .oMidiRd(rd_nf), .oMidiRe(re_nf), .oFrameErr(ferr_nf), .oBusy(busy_nf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (re) begin
      got_bytes.push_back(rd);
      got_cyc.push_back(cyc);
    end
    if (re_nf) nf_bytes.push_back(rd_nf);
    if (ferr) ferr_cnt++;
    if ((re && ferr) || (re_nf && ferr_nf)) overlap++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got_bytes.delete();
    got_cyc.delete();
    nf_bytes.delete();
    ferr_cnt = 0;
  endtask

  // Drives one 10-slot frame; returns the cycle in which the start bit was driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop_bit;
    tick(16);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b0;
    tick(3);
    @(negedge clk);
    tests++;
    if (rd !== 8'h00 || re !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%h re=%b ferr=%b busy=%b, required 00 0 0 0", rd, re, ferr, busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    clear_log();
    tick(30);
    tests++;
    if (got_bytes.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_quiet: strobes=%0d busy=%b, required 0 0", got_bytes.size(), busy);
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_note_on();
    logic [7:0] exp_b[3] = '{8'h90, 8'h3C, 8'h64};
    int         st[3];
    clear_log();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, st[i]);
    tick(20);
    tests++;
    if (got_bytes.size() != 3) begin
      errors++;
      $display("FAIL note_on_count: got %0d strobes, required 3", got_bytes.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got_bytes[i] !== exp_b[i]) begin
          errors++;
          $display("FAIL note_on_byte%0d: got %h, required %h", i, got_bytes[i], exp_b[i]);
        end
        tests++;
        if (got_cyc[i] != st[i] + 155) begin
          errors++;
          $display("FAIL note_on_timing%0d: strobe at cycle %0d, required %0d", i, got_cyc[i], st[i] + 155);
        end
        $display("[TB] note_on: byte %h at cycle %0d", got_bytes[i], got_cyc[i]);
      end
    end
  endtask

  task automatic test_realtime();
    int st;
    clear_log();
    send_frame(8'h90, 1'b1, st);
    send_frame(8'hF8, 1'b1, st);
    @(negedge clk);
    tests++;
    if (rd !== 8'h90 || got_bytes.size() != 1) begin
      errors++;
      $display("FAIL rt_filter_hold: rd=%h strobes=%0d, required 90 1", rd, got_bytes.size());
    end
    tick(1);
    send_frame(8'h3C, 1'b1, st);
    tick(10);
    tests++;
    if (got_bytes.size() != 2 || got_bytes[0] !== 8'h90 || got_bytes[1] !== 8'h3C) begin
      errors++;
      $display("FAIL rt_filter_bytes: got %0d strobes, required 2 (90,3C)", got_bytes.size());
    end
    tests++;
    if (nf_bytes.size() != 3 || nf_bytes[0] !== 8'h90 || nf_bytes[1] !== 8'hF8 || nf_bytes[2] !== 8'h3C) begin
      errors++;
      $display("FAIL rt_passthru_bytes: got %0d strobes, required 3 (90,F8,3C)", nf_bytes.size());
    end
    $display("[TB] realtime: filtered=%0d passthrough=%0d", got_bytes.size(), nf_bytes.size());
  endtask

  task automatic test_frame_err();
    int st;
    int busy_low;
    clear_log();
    send_frame(8'h55, 1'b0, st);
    busy_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      @(posedge clk);
      #1;
    end
    tests++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL ferr_busy_hold: busy low in %0d cycles, required 0", busy_low);
    end
    rx = 1'b1;
    tick(6);
    tests++;
    if (busy !== 1'b0 || ferr_cnt != 1 || got_bytes.size() != 0) begin
      errors++;
      $display("FAIL ferr_pulse: busy=%b ferr_pulses=%0d strobes=%0d, required 0 1 0", busy, ferr_cnt, got_bytes.size());
    end
    send_frame(8'hA5, 1'b1, st);
    tick(10);
    tests++;
    if (got_bytes.size() != 1 || got_bytes[0] !== 8'hA5 || ferr_cnt != 1) begin
      errors++;
      $display("FAIL ferr_recover: strobes=%0d ferr_pulses=%0d, required 1 (A5) 1", got_bytes.size(), ferr_cnt);
    end
    $display("[TB] frame_err: pulses=%0d", ferr_cnt);
  endtask

  task automatic test_glitch();
    int st;
    clear_log();
    st = cyc;
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(1);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_rise: busy=%b at cycle %0d, required 1", busy, cyc);
    end
    while (cyc < st + 11) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_fall: busy=%b at cycle %0d, required 0", busy, cyc);
    end
    @(posedge clk);
    #1;
    tick(20);
    tests++;
    if (got_bytes.size() != 0 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL glitch_no_output: strobes=%0d ferr=%0d, required 0 0", got_bytes.size(), ferr_cnt);
    end
    $display("[TB] glitch: done");
  endtask

  task automatic test_midframe_reset();
    logic [7:0] b = 8'h3C;
    int         st;
    clear_log();
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = b[4];
    tick(8);
    rst = 1'b1;
    rx  = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(40);
    tests++;
    if (got_bytes.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_discard: strobes=%0d busy=%b, required 0 0", got_bytes.size(), busy);
    end
    send_frame(8'h7F, 1'b1, st);
    tick(10);
    tests++;
    if (got_bytes.size() != 1 || got_bytes[0] !== 8'h7F) begin
      errors++;
      $display("FAIL midreset_recover: strobes=%0d, required 1 (7F)", got_bytes.size());
    end
    tests++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL re_ferr_overlap: %0d cycles with both high, required 0", overlap);
    end
    $display("[TB] midframe_reset: done");
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_realtime();
    test_frame_err();
    test_glitch();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
